// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Game of Life generation engine:
//   - default grid geometry (X_SIZE cells per row, Y_SIZE rows, Y_WIDTH)
//   - controller state encoding
//   - B3/S23 rule constants and a per-cell rule helper
// ---------------------------------------------------------------------------
package life_pkg;

    localparam int X_SIZE  = 1280;
    localparam int Y_SIZE  = 720;
    localparam int Y_WIDTH = $clog2(Y_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // B3/S23: born with exactly 3 neighbours, survives with 2 or 3.
    localparam logic [3:0] BIRTH_COUNT = 4'd3;
    localparam logic [3:0] SURVIVE_LO  = 4'd2;
    localparam logic [3:0] SURVIVE_HI  = 4'd3;

    function automatic logic next_cell(input logic [3:0] n, input logic alive);
        return (n == BIRTH_COUNT) || (alive && ((n == SURVIVE_LO) || (n == SURVIVE_HI)));
    endfunction

endpackage

// File: rtl/life_row_calc.sv
// ---------------------------------------------------------------------------
// life_row_calc
// Purely combinational next-state calculation for one row of cells.
// Ports:
//   top      in  X_SIZE  row above the row being computed
//   mid      in  X_SIZE  row being computed (current state)
//   bot      in  X_SIZE  row below the row being computed
//   next_row out X_SIZE  next-generation state of mid
// Cells beyond either end of the row are dead (zero padding, no wrap).
// ---------------------------------------------------------------------------
module life_row_calc #(
    parameter int X_SIZE = life_pkg::X_SIZE
) (
    input  logic [X_SIZE-1:0] top,
    input  logic [X_SIZE-1:0] mid,
    input  logic [X_SIZE-1:0] bot,
    output logic [X_SIZE-1:0] next_row
);
    import life_pkg::*;

    // Padded copies: cell gi sits at padded index gi+1, its neighbours at gi and gi+2.
    logic [X_SIZE+1:0] top_p;
    logic [X_SIZE+1:0] mid_p;
    logic [X_SIZE+1:0] bot_p;

    assign top_p = {1'b0, top, 1'b0};
    assign mid_p = {1'b0, mid, 1'b0};
    assign bot_p = {1'b0, bot, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < X_SIZE; gi++) begin : g_cell
            logic [3:0] n;
            assign n = {3'b0, top_p[gi]} + {3'b0, top_p[gi+1]} + {3'b0, top_p[gi+2]}
                     + {3'b0, mid_p[gi]}                       + {3'b0, mid_p[gi+2]}
                     + {3'b0, bot_p[gi]} + {3'b0, bot_p[gi+1]} + {3'b0, bot_p[gi+2]};
            assign next_row[gi] = next_cell(n, mid[gi]);
        end
    endgenerate

endmodule

// File: rtl/life_next_gen.sv
// ---------------------------------------------------------------------------
// life_next_gen
// Computes one Game of Life generation from a source line BRAM into a
// destination line BRAM, one row at a time, with a 3-row register window.
// Ports:
//   out_stream_aclk in  1        clock
//   periph_resetn   in  1        synchronous active-low reset
//   start           in  1        request one generation (ignored if pause or busy)
//   pause           in  1        blocks acceptance of start
//   busy            out 1        generation in progress
//   done            out 1        one-cycle pulse after the last row write
//   gen_count       out 32       completed generations (wraps)
//   rd_en/rd_addr   out          source BRAM read request
//   rd_data         in  X_SIZE   source row, valid the cycle after rd_en
//   wr_en/wr_addr/wr_data out    destination BRAM row write
// Source and destination must be distinct BRAMs: reads run one row ahead.
// ---------------------------------------------------------------------------
module life_next_gen #(
    parameter int X_SIZE  = life_pkg::X_SIZE,
    parameter int Y_SIZE  = life_pkg::Y_SIZE,
    parameter int Y_WIDTH = $clog2(Y_SIZE)
) (
    input  logic               out_stream_aclk,
    input  logic               periph_resetn,
    input  logic               start,
    input  logic               pause,
    output logic               busy,
    output logic               done,
    output logic [31:0]        gen_count,
    output logic               rd_en,
    output logic [Y_WIDTH-1:0] rd_addr,
    input  logic [X_SIZE-1:0]  rd_data,
    output logic               wr_en,
    output logic [Y_WIDTH-1:0] wr_addr,
    output logic [X_SIZE-1:0]  wr_data
);
    import life_pkg::*;

    // Fetch counter must reach Y_SIZE (the all-zero row below the grid).
    localparam int F_WIDTH = $clog2(Y_SIZE + 1);

    state_e              state_q, state_d;
    logic [F_WIDTH-1:0]  f_q, f_d;
    logic [X_SIZE-1:0]   top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [Y_WIDTH-1:0]  calc_row_q, calc_row_d;
    logic [Y_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [X_SIZE-1:0]   wr_data_q, wr_data_d;
    logic [31:0]         gen_count_q, gen_count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;

    logic [X_SIZE-1:0]   bot_in;
    logic [X_SIZE-1:0]   next_row;

    // Row entering the window in SHIFT; below the grid it is all dead.
    assign bot_in = (f_q < F_WIDTH'(Y_SIZE)) ? rd_data : '0;

    // Evaluated on the post-shift window so wr_data can be registered on
    // the same edge the window advances.
    life_row_calc #(.X_SIZE(X_SIZE)) u_row_calc (
        .top      (mid_q),
        .mid      (bot_q),
        .bot      (bot_in),
        .next_row (next_row)
    );

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        top_d       = top_q;
        mid_d       = mid_q;
        bot_d       = bot_q;
        calc_row_d  = calc_row_q;
        rd_addr_d   = rd_addr_q;
        wr_data_d   = wr_data_q;
        gen_count_d = gen_count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !pause) begin
                    top_d   = '0;
                    mid_d   = '0;
                    bot_d   = '0;
                    f_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_SHIFT;
            ST_SHIFT: begin
                top_d = mid_q;
                mid_d = bot_q;
                bot_d = bot_in;
                f_d   = f_q + F_WIDTH'(1);
                if (f_q == '0) begin
                    // Only one real row in the window yet; fetch another.
                    state_d = ST_RD_REQ;
                end else begin
                    calc_row_d = Y_WIDTH'(f_q - F_WIDTH'(1));
                    wr_data_d  = next_row;
                    wr_en_d    = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (calc_row_q == Y_WIDTH'(Y_SIZE - 1)) begin
                    done_d      = 1'b1;
                    gen_count_d = gen_count_q + 32'd1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every entry into RD_REQ issues a read unless the fetch has run
        // past the last row.
        if ((state_d == ST_RD_REQ) && (f_d < F_WIDTH'(Y_SIZE))) begin
            rd_en_d   = 1'b1;
            rd_addr_d = Y_WIDTH'(f_d);
        end
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            state_q     <= ST_IDLE;
            f_q         <= '0;
            top_q       <= '0;
            mid_q       <= '0;
            bot_q       <= '0;
            calc_row_q  <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
            gen_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            calc_row_q  <= calc_row_d;
            rd_addr_q   <= rd_addr_d;
            wr_data_q   <= wr_data_d;
            gen_count_q <= gen_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_count_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = calc_row_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_life_next_gen.sv
// ---------------------------------------------------------------------------
// tb_life_next_gen
// Small-grid (8x6) bench: two-bank BRAM model, coordinate-based reference
// model, expected row writes queued at issue time and checked by a monitor.
// ---------------------------------------------------------------------------
module tb_life_next_gen;

    localparam int XS  = 8;
    localparam int YS  = 6;
    localparam int YW  = $clog2(YS);
    localparam int LAT = 3 * (YS + 1) + YS;

    typedef logic [YS-1:0][XS-1:0] grid_t;
    typedef struct packed {
        logic [YW-1:0] addr;
        logic [XS-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          periph_resetn;
    logic          start;
    logic          pause;
    logic          busy;
    logic          done;
    logic [31:0]   gen_count;
    logic          rd_en;
    logic [YW-1:0] rd_addr;
    logic [XS-1:0] rd_data;
    logic          wr_en;
    logic [YW-1:0] wr_addr;
    logic [XS-1:0] wr_data;

    always #5 clk = ~clk;

    life_next_gen #(.X_SIZE(XS), .Y_SIZE(YS), .Y_WIDTH(YW)) dut (
        .out_stream_aclk (clk),
        .periph_resetn   (periph_resetn),
        .start           (start),
        .pause           (pause),
        .busy            (busy),
        .done            (done),
        .gen_count       (gen_count),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data)
    );

    // Two-bank line memory: bank src_bank is read, the other bank is written.
    logic [XS-1:0] mem [2][YS];
    logic          src_bank;
    logic          ld_en;
    logic          ld_bank;
    logic [YW-1:0] ld_addr;
    logic [XS-1:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_bank][ld_addr] <= ld_data;
        if (rd_en) rd_data <= mem[src_bank][rd_addr];
        if (wr_en) mem[~src_bank][wr_addr] <= wr_data;
    end

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    longint accept_cyc = 0;
    int     exp_gen = 0;
    int     rd_cnt = 0;
    int     wr_cnt = 0;
    wr_t    exp_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: B3/S23 on an (x,y) grid, x=0 is the MSB, outside cells dead.
    function automatic grid_t life_ref(input grid_t g);
        grid_t r;
        r = '0;
        for (int y = 0; y < YS; y++) begin
            for (int x = 0; x < XS; x++) begin
                int n;
                bit alive;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int yy;
                        int xx;
                        yy = y + dy;
                        xx = x + dx;
                        if (!(dx == 0 && dy == 0) && yy >= 0 && yy < YS && xx >= 0 && xx < XS)
                            if (g[yy][XS-1-xx]) n++;
                    end
                end
                alive = g[y][XS-1-x];
                r[y][XS-1-x] = (n == 3) || (n == 2 && alive);
            end
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rd_en) rd_cnt++;
        if (wr_en) begin
            wr_cnt++;
            $display("write row %0d data %h (gen_count %0d)", wr_addr, wr_data, gen_count);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: actual row %0d data %h, required no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
        if (done) begin
            $display("done after %0d cycles, gen_count %0d", cyc - accept_cyc, gen_count);
            check("done_latency", 64'(cyc - accept_cyc), 64'(LAT));
            check("gen_count", 64'(gen_count), 64'(exp_gen));
            check("rows_pending_at_done", 64'(exp_q.size()), 64'd0);
        end
    end

    task automatic load_grid(input logic bank, input grid_t g);
        for (int y = 0; y < YS; y++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_bank = bank;
            ld_addr = YW'(y);
            ld_data = g[y];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input grid_t g, output grid_t nxt);
        nxt = life_ref(g);
        for (int y = 0; y < YS; y++) begin
            wr_t e;
            e.addr = YW'(y);
            e.data = nxt[y];
            exp_q.push_back(e);
        end
        exp_gen++;
        @(negedge clk);
        start = 1'b1;
        accept_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: actual no done in 200 cycles, required done");
        end
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic run_gen(input grid_t g, output grid_t nxt);
        load_grid(1'b0, g);
        src_bank = 1'b0;
        issue(g, nxt);
        wait_done();
    endtask

    initial begin
        grid_t g;
        grid_t r1;
        grid_t r2;
        int    r0;
        int    w0;
        bit    hit;

        periph_resetn = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        src_bank = 1'b0;
        ld_en    = 1'b0;
        ld_bank  = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_gen_count", 64'(gen_count), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        periph_resetn = 1'b1;
        @(negedge clk);

        // Vertical blinker
        g = '0;
        g[1] = 8'h10; g[2] = 8'h10; g[3] = 8'h10;
        run_gen(g, r1);

        // Corner block
        g = '0;
        g[0] = 8'hC0; g[1] = 8'hC0;
        run_gen(g, r1);

        // Bottom-right edge
        g = '0;
        g[5] = 8'h07;
        run_gen(g, r1);

        // start held with pause high: nothing happens
        r0 = rd_cnt;
        w0 = wr_cnt;
        pause = 1'b1;
        start = 1'b1;
        repeat (10) @(negedge clk);
        check("pause_busy", 64'(busy), 64'd0);
        check("pause_rd_en_count", 64'(rd_cnt - r0), 64'd0);
        check("pause_wr_en_count", 64'(wr_cnt - w0), 64'd0);
        start = 1'b0;
        pause = 1'b0;
        g = '0;
        g[1] = 8'h10; g[2] = 8'h10; g[3] = 8'h10;
        run_gen(g, r1);

        // Extra start while busy, then reset after the third write
        load_grid(1'b0, g);
        src_bank = 1'b0;
        w0 = wr_cnt;
        issue(g, r1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt >= w0 + 3) hit = 1'b1;
        end
        check("third_write_seen", 64'(hit), 64'd1);
        exp_q.delete();
        exp_gen = 0;
        periph_resetn = 1'b0;
        @(negedge clk);
        periph_resetn = 1'b1;
        r0 = rd_cnt;
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_gen_count", 64'(gen_count), 64'd0);
        check("post_reset_wr_en_count", 64'(wr_cnt - w0), 64'd0);
        check("post_reset_rd_en_count", 64'(rd_cnt - r0), 64'd0);
        run_gen(g, r1);

        // Ping-pong: second generation reads what the first one wrote
        exp_gen = 0;
        periph_resetn = 1'b0;
        @(negedge clk);
        periph_resetn = 1'b1;
        @(negedge clk);
        run_gen(g, r1);
        src_bank = 1'b1;
        issue(r1, r2);
        wait_done();
        check("pingpong_gen_count", 64'(gen_count), 64'd2);
        src_bank = 1'b0;

        // Randomized grids, with mid-generation pause and stray starts
        for (int k = 0; k < 8; k++) begin
            for (int y = 0; y < YS; y++) begin
                if (k < 4) g[y] = XS'($urandom);
                else       g[y] = XS'($urandom & $urandom);
            end
            load_grid(1'b0, g);
            src_bank = 1'b0;
            issue(g, r1);
            repeat ($urandom_range(1, 15)) @(negedge clk);
            if (k % 2 == 1) pause = 1'b1;
            else            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done();
            pause = 1'b0;
        end

        repeat (5) @(negedge clk);
        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/life_next_gen.md
Name: life_next_gen

Overview:
- Computes one Game of Life generation (B3/S23) from the source line BRAM and writes it to the destination line BRAM.
- Works row by row, using a 3-row sliding window held in registers.
- Sits upstream of the pixel generator output stage. It fills the BRAM that the output stage displays.
- The controller triggers it once per generation and also drives pause.

Parameters:
- X_SIZE, 1280, cells per row (one bit per cell, bit X_SIZE-1 = leftmost pixel x=0).
- Y_SIZE, 720, rows per grid.
- Y_WIDTH, $clog2(Y_SIZE), row address width.

Ports:
- out_stream_aclk  in  1  sole clock.
- periph_resetn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to compute one generation.
- pause  in  1  when high, start is ignored.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last row write.
- gen_count  out  32  number of completed generations.
- rd_en  out  1  source BRAM read enable.
- rd_addr  out  Y_WIDTH  source row address.
- rd_data  in  X_SIZE  source row data, valid the cycle after the RD_REQ cycle.
- wr_en  out  1  destination BRAM write strobe.
- wr_addr  out  Y_WIDTH  destination row address.
- wr_data  out  X_SIZE  next-state row.

Behaviour:
- Reset state: the block is in IDLE with registers cleared.
  - Outputs: busy=0, done=0, gen_count=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0.
  - Window registers top, mid and bot are all 0.
- Reset mid-operation: the block returns to IDLE on the next edge.
  - No further rd_en or wr_en pulses occur.
  - gen_count is cleared.
- FSM states: IDLE, RD_REQ, RD_WAIT, SHIFT, WRITE, DONE. The fetch counter f runs 0..Y_SIZE.
- IDLE:
  - On start=1 and pause=0: top/mid/bot <= 0, f <= 0, busy <= 1, go to RD_REQ.
  - start while pause=1 is dropped, not queued.
- RD_REQ: if f<Y_SIZE, drive rd_en=1 and rd_addr=f; otherwise rd_en=0. Go to RD_WAIT.
- RD_WAIT: one cycle of BRAM latency, then go to SHIFT.
- SHIFT:
  - Update the window: top<=mid, mid<=bot, bot<=(f<Y_SIZE ? rd_data : 0), f<=f+1.
  - If the old f==0, go to RD_REQ. Otherwise register calc_row=f-1 and go to WRITE.
- WRITE:
  - For one cycle: wr_en=1, wr_addr=calc_row, wr_data=next(top,mid,bot).
  - If calc_row==Y_SIZE-1, go to DONE; otherwise go to RD_REQ.
- DONE: done=1 for one cycle, gen_count+=1 (wraps at 2^32), busy<=0, go to IDLE.
- Next-state rule, per cell: n = count of the 8 neighbours in top/mid/bot at columns x-1..x+1, excluding self.
  - The cell is alive if n==3, or if n==2 and the cell was alive.
- Boundaries:
  - Cells outside the grid are dead.
  - There is no wrap-around in x or y: column X_SIZE-1 has no right neighbour.
  - Row -1 is zero because the window starts at 0; row Y_SIZE is zero because bot is loaded with 0 when f==Y_SIZE.
- Write order: rows 0..Y_SIZE-1 ascending, exactly one wr_en per row.
- Source and destination must be distinct BRAMs, since reads run ahead of writes.
- Latency: from the start-accept edge to the done pulse is 3*(Y_SIZE+1)+Y_SIZE cycles; done follows in the cycle after the last write.
- start while busy=1 is ignored.
- A pause raised mid-generation does not stall; the current generation completes.
- rd_data is sampled only in SHIFT. wr_data is don't-care while wr_en=0 but is held registered.

Decomposition:
- Shared package life_pkg holds:
  - X_SIZE, Y_SIZE and Y_WIDTH constants;
  - the FSM state enumeration (3-bit);
  - the B3/S23 rule constants (birth count 3, survive counts 2 and 3).
- Sub-module life_row_calc: purely combinational. Takes top, mid and bot (X_SIZE each) and produces next (X_SIZE).
  - One 4-bit neighbour adder per cell, with zero padding at both ends.
  - It is reused by the planned software-model cross-check bench.

Test Plan:
- Vertical blinker (X_SIZE=8, Y_SIZE=6): src rows 1,2,3 = 8'h10, others 0; pulse start.
  - Writes must be rows 0..5 = 00,00,38,00,00,00.
  - done must occur exactly 27 cycles after start is accepted; gen_count=1.
- Corner block: rows 0,1 = 8'hC0, others 0 → dst rows 0,1 = C0, others 00 (edge cells treated as dead, no wrap).
- Bottom-right edge: row 5 = 8'h07, others 0 → dst row 4 = 02, row 5 = 02, others 00.
- start held high with pause=1 for 10 cycles → no rd_en, no wr_en, busy=0. Then drop pause and pulse start → one normal generation.
- A second start pulse while busy=1, followed by periph_resetn=0 for 1 cycle after the 3rd write:
  - The extra start is ignored, and no wr_en is seen after reset.
  - busy=0 and gen_count=0; a fresh start then completes a full generation.
- Two back-to-back generations, ping-ponging BRAM models, blinker input → outputs 38-row pattern, then the original vertical 10 pattern; gen_count=2.
